// File: rtl/paddle_ctrl_if.sv
// Button/frame inputs and paddle-state outputs between the game logic and paddle_ctrl.
interface paddle_ctrl_if #(
    parameter int Y_W = 10
);
    logic           frame_tick;
    logic           up_n;
    logic           dn_n;
    logic           center_req;
    logic [Y_W-1:0] paddle_y;
    logic           moving;
    logic           at_top;
    logic           at_bottom;

    modport master (
        output frame_tick, up_n, dn_n, center_req,
        input  paddle_y, moving, at_top, at_bottom
    );

    modport slave (
        input  frame_tick, up_n, dn_n, center_req,
        output paddle_y, moving, at_top, at_bottom
    );
endinterface

// File: rtl/paddle_ctrl.sv
// Frame-rate paddle position controller: first step on the next frame after a press,
// auto-repeat after a hold delay, clamped to the play field, with a centre/lock request.
module paddle_ctrl #(
    parameter int Y_W          = 10,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 480,
    parameter int PADDLE_H     = 80,
    parameter int SPEED        = 4,
    parameter int REPEAT_DELAY = 15
) (
    input logic          in_clk,
    input logic          in_rst,
    paddle_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FIRST  = 3'd1;
    localparam logic [2:0] S_HOLD   = 3'd2;
    localparam logic [2:0] S_REPEAT = 3'd3;
    localparam logic [2:0] S_LOCK   = 3'd4;

    localparam logic [Y_W:0] L_MIN = (Y_W+1)'(Y_MIN);
    localparam logic [Y_W:0] L_BOT = (Y_W+1)'(Y_MAX - PADDLE_H);
    localparam logic [Y_W:0] L_CTR = (Y_W+1)'((Y_MIN + Y_MAX - PADDLE_H) / 2);
    localparam logic [Y_W:0] L_SPD = (Y_W+1)'(SPEED);

    logic [2:0]       r_state;
    logic             r_dir;      // 1 = moving down
    logic [CNT_W-1:0] r_cnt;
    logic [Y_W-1:0]   r_y;
    logic             r_moving, r_top, r_bot;

    logic             w_dir_valid, w_req_dn;
    logic [Y_W:0]     w_y_ext, w_y_sum, w_y_up, w_y_dn, w_step;
    logic [2:0]       w_state_nxt;
    logic             w_dir_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [Y_W-1:0]   w_y_nxt;

    assign w_dir_valid = bus.up_n ^ bus.dn_n;
    assign w_req_dn    = ~bus.dn_n;

    // One extra bit of headroom so neither direction can wrap before clamping.
    assign w_y_ext = {1'b0, r_y};
    assign w_y_sum = w_y_ext + L_SPD;
    assign w_y_up  = (w_y_ext < L_MIN + L_SPD) ? L_MIN : w_y_ext - L_SPD;
    assign w_y_dn  = (w_y_sum > L_BOT) ? L_BOT : w_y_sum;
    assign w_step  = r_dir ? w_y_dn : w_y_up;

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_y_nxt     = r_y;
        if (bus.center_req) begin
            w_state_nxt = S_LOCK;
            w_cnt_nxt   = '0;
            w_y_nxt     = L_CTR[Y_W-1:0];
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dir_valid) begin
                        w_state_nxt = S_FIRST;
                        w_dir_nxt   = w_req_dn;
                    end
                end
                S_FIRST, S_HOLD, S_REPEAT: begin
                    if (!w_dir_valid) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_req_dn != r_dir) begin
                        w_state_nxt = S_FIRST;
                        w_dir_nxt   = w_req_dn;
                    end else if (bus.frame_tick) begin
                        if (r_state == S_FIRST) begin
                            w_y_nxt     = w_step[Y_W-1:0];
                            w_cnt_nxt   = CNT_W'(REPEAT_DELAY);
                            w_state_nxt = S_HOLD;
                        end else if (r_state == S_HOLD) begin
                            w_cnt_nxt = r_cnt - 1'b1;
                            if (r_cnt == CNT_W'(1)) w_state_nxt = S_REPEAT;
                        end else begin
                            w_y_nxt = w_step[Y_W-1:0];
                        end
                    end
                end
                S_LOCK: begin
                    if (bus.up_n && bus.dn_n) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Flags come from the next position so they never lag paddle_y.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_state  <= S_IDLE;
            r_dir    <= 1'b0;
            r_cnt    <= '0;
            r_y      <= L_CTR[Y_W-1:0];
            r_moving <= 1'b0;
            r_top    <= 1'b0;
            r_bot    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_y      <= w_y_nxt;
            r_moving <= (w_state_nxt == S_FIRST) || (w_state_nxt == S_HOLD) ||
                        (w_state_nxt == S_REPEAT);
            r_top    <= (w_y_nxt == L_MIN[Y_W-1:0]);
            r_bot    <= (w_y_nxt == L_BOT[Y_W-1:0]);
        end
    end

    assign bus.paddle_y  = r_y;
    assign bus.moving    = r_moving;
    assign bus.at_top    = r_top;
    assign bus.at_bottom = r_bot;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench: default-parameter DUT plus a SPEED=6 copy that reaches the clamp limits off-grid.
module tb_paddle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0, up_n = 1'b1, dn_n = 1'b1, creq = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    paddle_ctrl_if #(.Y_W(10)) if1 ();
    paddle_ctrl_if #(.Y_W(10)) if2 ();

    assign if1.frame_tick = tick;
    assign if1.up_n       = up_n;
    assign if1.dn_n       = dn_n;
    assign if1.center_req = creq;
    assign if2.frame_tick = tick;
    assign if2.up_n       = up_n;
    assign if2.dn_n       = dn_n;
    assign if2.center_req = creq;

    paddle_ctrl dut (.in_clk(clk), .in_rst(rst), .bus(if1));
    paddle_ctrl #(.SPEED(6)) dut6 (.in_clk(clk), .in_rst(rst), .bus(if2));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One frame_tick pulse followed by one quiet cycle.
    task automatic step_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        up_n = 1'b0;
        do_reset();
        checks++;
        if (if1.paddle_y !== 10'd200 || if1.moving !== 1'b0 || if1.at_top !== 1'b0 || if1.at_bottom !== 1'b0) begin
            errors++;
            $display("FAIL reset_state y=%0d mv=%b top=%b bot=%b want 200 0 0 0",
                     if1.paddle_y, if1.moving, if1.at_top, if1.at_bottom);
        end
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        checks++;
        if (if1.paddle_y !== 10'd200 || if1.moving !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_tick y=%0d mv=%b want 200 1", if1.paddle_y, if1.moving);
        end
        cyc();
        step_tick();
        checks++;
        if (if1.paddle_y !== 10'd196) begin
            errors++;
            $display("FAIL reset_second_tick y=%0d want 196", if1.paddle_y);
        end
        up_n = 1'b1;
        cyc();
        checks++;
        if (if1.moving !== 1'b0) begin
            errors++;
            $display("FAIL reset_release mv=%b want 0", if1.moving);
        end
    endtask

    task automatic test_hold_repeat();
        int exp;
        do_reset();
        up_n = 1'b0;
        cyc();
        for (int t = 1; t <= 20; t++) begin
            step_tick();
            exp = (t <= 16) ? 196 : 196 - 4 * (t - 16);
            checks++;
            if (if1.paddle_y !== 10'(exp) || if1.moving !== 1'b1) begin
                errors++;
                $display("FAIL hold_repeat tick=%0d y=%0d mv=%b want %0d 1", t, if1.paddle_y, if1.moving, exp);
            end
        end
        up_n = 1'b1;
        cyc();
    endtask

    task automatic test_clamp();
        int exp;
        do_reset();
        dn_n = 1'b0;
        cyc();
        exp = 200;
        for (int t = 1; t <= 52; t++) begin
            step_tick();
            if (t == 1 || t >= 17) exp = (exp + 6 > 400) ? 400 : exp + 6;
            checks++;
            if (if2.paddle_y !== 10'(exp) || if2.at_bottom !== (exp == 400)) begin
                errors++;
                $display("FAIL clamp_bottom tick=%0d y=%0d bot=%b want %0d %0d", t, if2.paddle_y, if2.at_bottom, exp, exp == 400);
            end
        end
        dn_n = 1'b1;
        do_reset();
        up_n = 1'b0;
        cyc();
        exp = 200;
        for (int t = 1; t <= 52; t++) begin
            step_tick();
            if (t == 1 || t >= 17) exp = (exp < 6) ? 0 : exp - 6;
            checks++;
            if (if2.paddle_y !== 10'(exp) || if2.at_top !== (exp == 0)) begin
                errors++;
                $display("FAIL clamp_top tick=%0d y=%0d top=%b want %0d %0d", t, if2.paddle_y, if2.at_top, exp, exp == 0);
            end
        end
        up_n = 1'b1;
        cyc();
    endtask

    task automatic test_conflict();
        do_reset();
        up_n = 1'b0;
        dn_n = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            step_tick();
            checks++;
            if (if1.paddle_y !== 10'd200 || if1.moving !== 1'b0) begin
                errors++;
                $display("FAIL both_pressed tick=%0d y=%0d mv=%b want 200 0", t, if1.paddle_y, if1.moving);
            end
        end
        up_n = 1'b1;
        dn_n = 1'b1;
        cyc();
    endtask

    task automatic test_dir_change();
        int exp;
        do_reset();
        up_n = 1'b0;
        cyc();
        for (int t = 1; t <= 17; t++) step_tick();
        checks++;
        if (if1.paddle_y !== 10'd192) begin
            errors++;
            $display("FAIL dirchg_pre y=%0d want 192", if1.paddle_y);
        end
        up_n = 1'b1;
        dn_n = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        checks++;
        if (if1.paddle_y !== 10'd192 || if1.moving !== 1'b1) begin
            errors++;
            $display("FAIL dirchg_switch y=%0d mv=%b want 192 1", if1.paddle_y, if1.moving);
        end
        cyc();
        for (int t = 1; t <= 17; t++) begin
            step_tick();
            exp = (t <= 16) ? 196 : 200;
            checks++;
            if (if1.paddle_y !== 10'(exp)) begin
                errors++;
                $display("FAIL dirchg_down tick=%0d y=%0d want %0d", t, if1.paddle_y, exp);
            end
        end
        dn_n = 1'b1;
        cyc();
    endtask

    task automatic test_center_lock();
        do_reset();
        up_n = 1'b0;
        cyc();
        for (int t = 1; t <= 55; t++) step_tick();
        checks++;
        if (if1.paddle_y !== 10'd40) begin
            errors++;
            $display("FAIL lock_pre y=%0d want 40", if1.paddle_y);
        end
        creq = 1'b1;
        tick = 1'b1;
        cyc();
        creq = 1'b0;
        tick = 1'b0;
        checks++;
        if (if1.paddle_y !== 10'd200 || if1.moving !== 1'b0 || if1.at_top !== 1'b0 || if1.at_bottom !== 1'b0) begin
            errors++;
            $display("FAIL lock_center y=%0d mv=%b top=%b bot=%b want 200 0 0 0",
                     if1.paddle_y, if1.moving, if1.at_top, if1.at_bottom);
        end
        for (int t = 1; t <= 5; t++) begin
            step_tick();
            checks++;
            if (if1.paddle_y !== 10'd200 || if1.moving !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold tick=%0d y=%0d mv=%b want 200 0", t, if1.paddle_y, if1.moving);
            end
        end
        up_n = 1'b1;
        cyc();
        up_n = 1'b0;
        cyc();
        step_tick();
        checks++;
        if (if1.paddle_y !== 10'd196) begin
            errors++;
            $display("FAIL lock_repress y=%0d want 196", if1.paddle_y);
        end
        up_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset_mid_repeat();
        int exp;
        do_reset();
        up_n = 1'b0;
        cyc();
        for (int t = 1; t <= 35; t++) step_tick();
        checks++;
        if (if1.paddle_y !== 10'd120) begin
            errors++;
            $display("FAIL midrst_pre y=%0d want 120", if1.paddle_y);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (if1.paddle_y !== 10'd200 || if1.moving !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state y=%0d mv=%b want 200 0", if1.paddle_y, if1.moving);
        end
        cyc();
        for (int t = 1; t <= 17; t++) begin
            step_tick();
            exp = (t <= 16) ? 196 : 192;
            checks++;
            if (if1.paddle_y !== 10'(exp)) begin
                errors++;
                $display("FAIL midrst_restart tick=%0d y=%0d want %0d", t, if1.paddle_y, exp);
            end
        end
        up_n = 1'b1;
        cyc();
    endtask

    initial begin
        cyc();
        test_reset();
        test_hold_repeat();
        test_clamp();
        test_conflict();
        test_dir_change();
        test_center_lock();
        test_reset_mid_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
